pipe_ctrl_unit: RTL and testbench



---
 rtl/pipe_ctrl_unit_pkg.sv | 41 ++++
 rtl/pipe_ctrl_unit_if.sv | 37 +++
 rtl/pipe_ctrl_unit_decode.sv | 96 +++++++++
 rtl/pipe_ctrl_unit.sv | 163 ++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_unit_pkg.sv
// pipe_ctrl_pkg: shared constants for the ID-stage control and hazard unit.
// Holds MIPS opcode/function encodings, ALU-control codes, operand-forward
// select codes and next-PC source codes.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  typedef enum logic [1:0] {
    FWD_RF     = 2'b00,
    FWD_EXALU  = 2'b01,
    FWD_MEMALU = 2'b10,
    FWD_MEMLD  = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pcsrc_e;

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// pipe_ctrl_unit_if: datapath <-> control-unit bundle.
// slave  : control unit side (takes instr/rsrtequ, drives all controls).
// master : datapath side (drives instr/rsrtequ, consumes all controls).
interface pipe_ctrl_unit_if #(
  parameter int RA_W   = 5,
  parameter int ALUC_W = 3
);
  logic [31:0]       instr;
  logic              rsrtequ;
  logic              wreg, m2reg, wmem, aluimm, regrt, sext, illegal;
  logic [ALUC_W-1:0] aluc;
  logic              ewreg, em2reg, ewmem, ealuimm;
  logic [ALUC_W-1:0] ealuc;
  logic [RA_W-1:0]   ern;
  logic              mwreg, mm2reg, mwmem;
  logic [RA_W-1:0]   mrn;
  logic              wwreg, wm2reg;
  logic [RA_W-1:0]   wrn;
  logic [1:0]        fwda, fwdb, pcsrc;
  logic              wpcir;

  modport master (
    output instr, rsrtequ,
    input  wreg, m2reg, wmem, aluimm, regrt, sext, illegal, aluc,
    input  ewreg, em2reg, ewmem, ealuimm, ealuc, ern,
    input  mwreg, mm2reg, mwmem, mrn, wwreg, wm2reg, wrn,
    input  fwda, fwdb, pcsrc, wpcir
  );

  modport slave (
    input  instr, rsrtequ,
    output wreg, m2reg, wmem, aluimm, regrt, sext, illegal, aluc,
    output ewreg, em2reg, ewmem, ealuimm, ealuc, ern,
    output mwreg, mm2reg, mwmem, mrn, wwreg, wm2reg, wrn,
    output fwda, fwdb, pcsrc, wpcir
  );
endinterface

// File: rtl/pipe_ctrl_unit_decode.sv
// ctrl_decode: purely combinational ID-stage instruction decoder.
// Inputs : op (instr[31:26]), fn (instr[5:0]).
// Outputs: ID controls wreg/m2reg/wmem/aluimm/regrt/sext/aluc, source-use
//          flags use_rs/use_rt, branch/jump kind flags and illegal.
// Unsupported encodings decode to a NOP with illegal set.
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int ALUC_W = 3
) (
  input  logic [5:0]        op,
  input  logic [5:0]        fn,
  output logic              wreg,
  output logic              m2reg,
  output logic              wmem,
  output logic              aluimm,
  output logic              regrt,
  output logic              sext,
  output logic [ALUC_W-1:0] aluc,
  output logic              use_rs,
  output logic              use_rt,
  output logic              is_beq,
  output logic              is_bne,
  output logic              is_j,
  output logic              illegal
);

  logic [2:0] alu_op;

  always_comb begin
    wreg    = 1'b0;
    m2reg   = 1'b0;
    wmem    = 1'b0;
    aluimm  = 1'b0;
    regrt   = 1'b0;
    sext    = 1'b0;
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    illegal = 1'b0;
    alu_op  = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        wreg   = 1'b1;
        use_rs = 1'b1;
        use_rt = 1'b1;
        case (fn)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: begin
            wreg    = 1'b0;
            use_rs  = 1'b0;
            use_rt  = 1'b0;
            illegal = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        wreg = 1'b1; m2reg = 1'b1; aluimm = 1'b1; regrt = 1'b1; sext = 1'b1;
        use_rs = 1'b1;
      end
      OP_SW: begin
        wmem = 1'b1; aluimm = 1'b1; sext = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
      end
      OP_ADDI: begin
        wreg = 1'b1; aluimm = 1'b1; regrt = 1'b1; sext = 1'b1; use_rs = 1'b1;
      end
      OP_ANDI: begin
        wreg = 1'b1; aluimm = 1'b1; regrt = 1'b1; use_rs = 1'b1;
        alu_op = ALU_AND;
      end
      OP_ORI: begin
        wreg = 1'b1; aluimm = 1'b1; regrt = 1'b1; use_rs = 1'b1;
        alu_op = ALU_OR;
      end
      OP_BEQ: begin
        is_beq = 1'b1; sext = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
        alu_op = ALU_SUB;
      end
      OP_BNE: begin
        is_bne = 1'b1; sext = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
        alu_op = ALU_SUB;
      end
      OP_J:    is_j = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  assign aluc = ALUC_W'(alu_op);

endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: ID-stage control and hazard unit for the 5-stage MIPS core.
// Ports: clk, rst (sync, active-high), bus (pipe_ctrl_unit_if.slave):
//   instr/rsrtequ in; ID controls, EX/MEM/WB stage controls and destinations,
//   fwda/fwdb operand selects, wpcir (0 = stall), pcsrc, illegal out.
// FWD_EN=1 forwards and stalls only on load-use / branch-on-EX-result;
// FWD_EN=0 stalls on every RAW hazard against EX or MEM.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter bit FWD_EN = 1'b1,
  parameter int RA_W   = 5,
  parameter int ALUC_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_unit_if.slave  bus
);

  logic              wreg, m2reg, wmem, aluimm, regrt, sext, illegal;
  logic [ALUC_W-1:0] aluc;
  logic              use_rs, use_rt, is_beq, is_bne, is_j;
  logic [RA_W-1:0]   rs, rt, rd, rn;
  logic              unused_instr;

  logic              ewreg_p1, em2reg_p1, ewmem_p1, ealuimm_p1;
  logic [ALUC_W-1:0] ealuc_p1;
  logic [RA_W-1:0]   ern_p1;
  logic              mwreg_p2, mm2reg_p2, mwmem_p2;
  logic [RA_W-1:0]   mrn_p2;
  logic              wwreg_p3, wm2reg_p3;
  logic [RA_W-1:0]   wrn_p3;

  logic              ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic              stall;
  fwd_sel_e          fwda, fwdb;
  pcsrc_e            pcsrc;

  function automatic fwd_sel_e fwd_pick(input logic ex_hit, input logic mem_hit,
                                        input logic ex_load, input logic mem_load);
    if (ex_hit && !ex_load) return FWD_EXALU;
    if (mem_hit)            return mem_load ? FWD_MEMLD : FWD_MEMALU;
    return FWD_RF;
  endfunction

  ctrl_decode #(.ALUC_W(ALUC_W)) u_dec (
    .op      (bus.instr[31:26]),
    .fn      (bus.instr[5:0]),
    .wreg    (wreg),
    .m2reg   (m2reg),
    .wmem    (wmem),
    .aluimm  (aluimm),
    .regrt   (regrt),
    .sext    (sext),
    .aluc    (aluc),
    .use_rs  (use_rs),
    .use_rt  (use_rt),
    .is_beq  (is_beq),
    .is_bne  (is_bne),
    .is_j    (is_j),
    .illegal (illegal)
  );

  assign rs           = RA_W'(bus.instr[25:21]);
  assign rt           = RA_W'(bus.instr[20:16]);
  assign rd           = RA_W'(bus.instr[15:11]);
  assign rn           = regrt ? rt : rd;
  assign unused_instr = ^bus.instr[10:6];

  // ID: hazard compare against EX/MEM; register 0 never matches
  assign ex_hit_a  = ewreg_p1 && (ern_p1 != '0) && use_rs && (ern_p1 == rs);
  assign ex_hit_b  = ewreg_p1 && (ern_p1 != '0) && use_rt && (ern_p1 == rt);
  assign mem_hit_a = mwreg_p2 && (mrn_p2 != '0) && use_rs && (mrn_p2 == rs);
  assign mem_hit_b = mwreg_p2 && (mrn_p2 != '0) && use_rt && (mrn_p2 == rt);

  always_comb begin
    fwda  = FWD_RF;
    fwdb  = FWD_RF;
    stall = 1'b0;
    if (FWD_EN) begin
      fwda  = fwd_pick(ex_hit_a, mem_hit_a, em2reg_p1, mm2reg_p2);
      fwdb  = fwd_pick(ex_hit_b, mem_hit_b, em2reg_p1, mm2reg_p2);
      // Load data is not ready in EX, and branches compare in ID, so both
      // must wait one cycle for an EX-stage producer.
      stall = (ex_hit_a || ex_hit_b) && (em2reg_p1 || is_beq || is_bne);
    end else begin
      stall = ex_hit_a || ex_hit_b || mem_hit_a || mem_hit_b;
    end
    pcsrc = PC_SEQ;
    if (!stall) begin
      if ((is_beq && bus.rsrtequ) || (is_bne && !bus.rsrtequ)) pcsrc = PC_BRANCH;
      else if (is_j)                                           pcsrc = PC_JUMP;
    end
  end

  // ID/EX (p1) -> EX/MEM (p2) -> MEM/WB (p3)
  always_ff @(posedge clk) begin
    if (rst) begin
      ewreg_p1   <= 1'b0;
      em2reg_p1  <= 1'b0;
      ewmem_p1   <= 1'b0;
      ealuimm_p1 <= 1'b0;
      ealuc_p1   <= '0;
      ern_p1     <= '0;
      mwreg_p2   <= 1'b0;
      mm2reg_p2  <= 1'b0;
      mwmem_p2   <= 1'b0;
      mrn_p2     <= '0;
      wwreg_p3   <= 1'b0;
      wm2reg_p3  <= 1'b0;
      wrn_p3     <= '0;
    end else begin
      if (stall) begin
        ewreg_p1   <= 1'b0;
        em2reg_p1  <= 1'b0;
        ewmem_p1   <= 1'b0;
        ealuimm_p1 <= 1'b0;
        ealuc_p1   <= '0;
        ern_p1     <= '0;
      end else begin
        ewreg_p1   <= wreg;
        em2reg_p1  <= m2reg;
        ewmem_p1   <= wmem;
        ealuimm_p1 <= aluimm;
        ealuc_p1   <= aluc;
        ern_p1     <= rn;
      end
      mwreg_p2  <= ewreg_p1;
      mm2reg_p2 <= em2reg_p1;
      mwmem_p2  <= ewmem_p1;
      mrn_p2    <= ern_p1;
      wwreg_p3  <= mwreg_p2;
      wm2reg_p3 <= mm2reg_p2;
      wrn_p3    <= mrn_p2;
    end
  end

  assign bus.wreg    = wreg;
  assign bus.m2reg   = m2reg;
  assign bus.wmem    = wmem;
  assign bus.aluimm  = aluimm;
  assign bus.regrt   = regrt;
  assign bus.sext    = sext;
  assign bus.aluc    = aluc;
  assign bus.illegal = illegal;
  assign bus.ewreg   = ewreg_p1;
  assign bus.em2reg  = em2reg_p1;
  assign bus.ewmem   = ewmem_p1;
  assign bus.ealuimm = ealuimm_p1;
  assign bus.ealuc   = ealuc_p1;
  assign bus.ern     = ern_p1;
  assign bus.mwreg   = mwreg_p2;
  assign bus.mm2reg  = mm2reg_p2;
  assign bus.mwmem   = mwmem_p2;
  assign bus.mrn     = mrn_p2;
  assign bus.wwreg   = wwreg_p3;
  assign bus.wm2reg  = wm2reg_p3;
  assign bus.wrn     = wrn_p3;
  assign bus.fwda    = fwda;
  assign bus.fwdb    = fwdb;
  assign bus.pcsrc   = pcsrc;
  assign bus.wpcir   = !stall;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: one forwarding instance and one interlock-only
// instance share the same instruction stream and are each compared every
// cycle with an instruction-level reference model, plus directed checks.
module tb_pipe_ctrl_unit;

  typedef struct packed {
    bit       wr;
    bit       ld;
    bit       st;
    bit       alui;
    bit [2:0] aluc;
    bit [4:0] rn;
  } stg_t;

  typedef struct {
    bit wr, ld, st, alui, rtdst, sx, ill, urs, urt, beq, bne, jmp;
    bit [2:0] aluc;
    bit [4:0] rs, rt, rd;
  } dec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cur_instr = '0;
  logic        cur_eq = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl_unit_if #(.RA_W(5), .ALUC_W(3)) bus_f ();
  pipe_ctrl_unit_if #(.RA_W(5), .ALUC_W(3)) bus_i ();

  pipe_ctrl_unit #(.FWD_EN(1'b1), .RA_W(5), .ALUC_W(3)) dut_f (
    .clk (clk), .rst (rst), .bus (bus_f.slave));
  pipe_ctrl_unit #(.FWD_EN(1'b0), .RA_W(5), .ALUC_W(3)) dut_i (
    .clk (clk), .rst (rst), .bus (bus_i.slave));

  assign bus_f.instr   = cur_instr;
  assign bus_i.instr   = cur_instr;
  assign bus_f.rsrtequ = cur_eq;
  assign bus_i.rsrtequ = cur_eq;

  logic [9:0]  id_o  [2];
  logic [11:0] ex_o  [2];
  logic [7:0]  mem_o [2];
  logic [6:0]  wb_o  [2];
  logic [6:0]  hz_o  [2];

  assign id_o[0]  = {bus_f.wreg, bus_f.m2reg, bus_f.wmem, bus_f.aluimm, bus_f.regrt,
                     bus_f.sext, bus_f.aluc, bus_f.illegal};
  assign id_o[1]  = {bus_i.wreg, bus_i.m2reg, bus_i.wmem, bus_i.aluimm, bus_i.regrt,
                     bus_i.sext, bus_i.aluc, bus_i.illegal};
  assign ex_o[0]  = {bus_f.ewreg, bus_f.em2reg, bus_f.ewmem, bus_f.ealuimm, bus_f.ealuc, bus_f.ern};
  assign ex_o[1]  = {bus_i.ewreg, bus_i.em2reg, bus_i.ewmem, bus_i.ealuimm, bus_i.ealuc, bus_i.ern};
  assign mem_o[0] = {bus_f.mwreg, bus_f.mm2reg, bus_f.mwmem, bus_f.mrn};
  assign mem_o[1] = {bus_i.mwreg, bus_i.mm2reg, bus_i.mwmem, bus_i.mrn};
  assign wb_o[0]  = {bus_f.wwreg, bus_f.wm2reg, bus_f.wrn};
  assign wb_o[1]  = {bus_i.wwreg, bus_i.wm2reg, bus_i.wrn};
  assign hz_o[0]  = {bus_f.fwda, bus_f.fwdb, bus_f.wpcir, bus_f.pcsrc};
  assign hz_o[1]  = {bus_i.fwda, bus_i.fwdb, bus_i.wpcir, bus_i.pcsrc};

  int   tests = 0;
  int   fails = 0;
  stg_t ex_m [2];
  stg_t mem_m[2];
  stg_t wb_m [2];
  bit   stl_m[2];
  dec_t dec_m;

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] s,
                                        input logic [4:0] t, input logic [4:0] d);
    return {6'h00, s, t, d, 5'h00, f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  // ---------------- reference model ----------------
  function automatic dec_t mdecode(input logic [31:0] w);
    dec_t d;
    d = '{default: '0};
    d.rs = w[25:21];
    d.rt = w[20:16];
    d.rd = w[15:11];
    case (w[31:26])
      6'h00: begin
        case (w[5:0])
          6'h20:   d.aluc = 3'd0;
          6'h22:   d.aluc = 3'd1;
          6'h24:   d.aluc = 3'd2;
          6'h25:   d.aluc = 3'd3;
          6'h2a:   d.aluc = 3'd4;
          default: d.ill  = 1'b1;
        endcase
        if (!d.ill) begin d.wr = 1; d.urs = 1; d.urt = 1; end
      end
      6'h23: begin d.wr = 1; d.ld = 1; d.alui = 1; d.rtdst = 1; d.sx = 1; d.urs = 1; end
      6'h2b: begin d.st = 1; d.alui = 1; d.sx = 1; d.urs = 1; d.urt = 1; end
      6'h08: begin d.wr = 1; d.alui = 1; d.rtdst = 1; d.sx = 1; d.urs = 1; end
      6'h0c: begin d.wr = 1; d.alui = 1; d.rtdst = 1; d.urs = 1; d.aluc = 3'd2; end
      6'h0d: begin d.wr = 1; d.alui = 1; d.rtdst = 1; d.urs = 1; d.aluc = 3'd3; end
      6'h04: begin d.beq = 1; d.sx = 1; d.urs = 1; d.urt = 1; d.aluc = 3'd1; end
      6'h05: begin d.bne = 1; d.sx = 1; d.urs = 1; d.urt = 1; d.aluc = 3'd1; end
      6'h02: d.jmp = 1;
      default: d.ill = 1;
    endcase
    return d;
  endfunction

  // Does instruction d read a register that stage s is going to write?
  function automatic bit dep(input stg_t s, input dec_t d);
    return s.wr && (s.rn != 5'd0) &&
           ((d.urs && d.rs == s.rn) || (d.urt && d.rt == s.rn));
  endfunction

  function automatic bit [1:0] mfwd(input int m, input bit used, input bit [4:0] r);
    if (m != 0 || !used || r == 5'd0) return 2'd0;
    if (ex_m[m].wr && !ex_m[m].ld && ex_m[m].rn == r) return 2'd1;
    if (mem_m[m].wr && mem_m[m].rn == r) return mem_m[m].ld ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_check(input int m);
    dec_t     d;
    bit       stl;
    bit [1:0] pc;
    d   = mdecode(cur_instr);
    stl = (m == 0) ? (dep(ex_m[m], d) && (ex_m[m].ld || d.beq || d.bne))
                   : (dep(ex_m[m], d) || dep(mem_m[m], d));
    if (stl)                                       pc = 2'd0;
    else if ((d.beq && cur_eq) || (d.bne && !cur_eq)) pc = 2'd1;
    else if (d.jmp)                                pc = 2'd2;
    else                                           pc = 2'd0;
    chk($sformatf("id[%0d]", m), 16'(id_o[m]),
        16'({d.wr, d.ld, d.st, d.alui, d.rtdst, d.sx, d.aluc, d.ill}));
    chk($sformatf("ex[%0d]", m), 16'(ex_o[m]), 16'(ex_m[m]));
    chk($sformatf("mem[%0d]", m), 16'(mem_o[m]),
        16'({mem_m[m].wr, mem_m[m].ld, mem_m[m].st, mem_m[m].rn}));
    chk($sformatf("wb[%0d]", m), 16'(wb_o[m]), 16'({wb_m[m].wr, wb_m[m].ld, wb_m[m].rn}));
    chk($sformatf("hazard[%0d]", m), 16'(hz_o[m]),
        16'({mfwd(m, d.urs, d.rs), mfwd(m, d.urt, d.rt), !stl, pc}));
    stl_m[m] = stl;
    dec_m    = d;
  endtask

  task automatic model_update();
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        ex_m[m] = '0; mem_m[m] = '0; wb_m[m] = '0;
      end else begin
        wb_m[m]  = mem_m[m];
        mem_m[m] = ex_m[m];
        ex_m[m]  = stl_m[m] ? '0 :
                   {dec_m.wr, dec_m.ld, dec_m.st, dec_m.alui, dec_m.aluc,
                    (dec_m.rtdst ? dec_m.rt : dec_m.rd)};
      end
    end
  endtask

  task automatic drive(input logic [31:0] w, input logic eq, input logic r);
    cur_instr = w;
    cur_eq    = eq;
    rst       = r;
    @(negedge clk);
    for (int m = 0; m < 2; m++) model_check(m);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic nops(input int n);
    for (int k = 0; k < n; k++) begin drive(32'h0, 1'b0, 1'b0); tick(); end
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [4:0]  s, t, d;
    logic [15:0] imm;
    s   = 5'($urandom_range(0, 7));
    t   = 5'($urandom_range(0, 7));
    d   = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    case ($urandom_range(0, 13))
      0:  return enc_r(6'h20, s, t, d);
      1:  return enc_r(6'h22, s, t, d);
      2:  return enc_r(6'h24, s, t, d);
      3:  return enc_r(6'h25, s, t, d);
      4:  return enc_r(6'h2a, s, t, d);
      5:  return enc_i(6'h23, s, t, imm);
      6:  return enc_i(6'h2b, s, t, imm);
      7:  return enc_i(6'h08, s, t, imm);
      8:  return enc_i(6'h0c, s, t, imm);
      9:  return enc_i(6'h0d, s, t, imm);
      10: return enc_i(6'h04, s, t, imm);
      11: return enc_i(6'h05, s, t, imm);
      12: return {6'h02, 26'($urandom)};
      default: return 32'($urandom);
    endcase
  endfunction

  // ---------------- directed then random sequence ----------------
  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    for (int m = 0; m < 2; m++) begin ex_m[m] = '0; mem_m[m] = '0; wb_m[m] = '0; end
    #1;

    // reset state
    drive(enc_r(6'h20, 5'd1, 5'd2, 5'd3), 1'b0, 1'b1);
    chk("rst_wpcir", 16'(bus_f.wpcir), 16'h1);
    chk("rst_fwd", 16'({bus_f.fwda, bus_f.fwdb}), 16'h0);
    chk("rst_stages", 16'({bus_f.ewreg, bus_f.mwreg, bus_f.wwreg, bus_f.ern}), 16'h0);
    tick();
    nops(3);

    // add $3 ; sub $4,$3,$5 -> EX forward
    drive(enc_r(6'h20, 5'd1, 5'd2, 5'd3), 1'b0, 1'b0); tick();
    drive(enc_r(6'h22, 5'd3, 5'd5, 5'd4), 1'b0, 1'b0);
    chk("exfwd_fwda", 16'(bus_f.fwda), 16'h1);
    chk("exfwd_wpcir", 16'(bus_f.wpcir), 16'h1);
    tick();
    nops(3);

    // add $3 ; nop ; sub -> MEM forward
    drive(enc_r(6'h20, 5'd1, 5'd2, 5'd3), 1'b0, 1'b0); tick();
    drive(32'h0, 1'b0, 1'b0); tick();
    drive(enc_r(6'h22, 5'd3, 5'd5, 5'd4), 1'b0, 1'b0);
    chk("memfwd_fwda", 16'(bus_f.fwda), 16'h2);
    tick();
    nops(3);

    // lw $3 ; add $4,$3,$3 -> one stall then load-data forward
    drive(enc_i(6'h23, 5'd1, 5'd3, 16'h0), 1'b0, 1'b0); tick();
    drive(enc_r(6'h20, 5'd3, 5'd3, 5'd4), 1'b0, 1'b0);
    chk("ldu_stall", 16'(bus_f.wpcir), 16'h0);
    tick();
    drive(enc_r(6'h20, 5'd3, 5'd3, 5'd4), 1'b0, 1'b0);
    chk("ldu_release", 16'(bus_f.wpcir), 16'h1);
    chk("ldu_bubble", 16'({bus_f.ewreg, bus_f.ern}), 16'h0);
    chk("ldu_fwd", 16'({bus_f.fwda, bus_f.fwdb}), 16'hf);
    tick();
    nops(3);

    // writes to $0 never forward or stall
    drive(enc_r(6'h20, 5'd1, 5'd2, 5'd0), 1'b0, 1'b0); tick();
    drive(enc_r(6'h20, 5'd0, 5'd0, 5'd4), 1'b0, 1'b0);
    chk("r0_fwd", 16'({bus_f.fwda, bus_f.fwdb, bus_f.wpcir}), 16'h1);
    tick();
    nops(3);

    // add $3 ; beq $3,$4 taken -> stall then branch ; j immediate
    drive(enc_r(6'h20, 5'd1, 5'd2, 5'd3), 1'b0, 1'b0); tick();
    drive(enc_i(6'h04, 5'd3, 5'd4, 16'h8), 1'b1, 1'b0);
    chk("br_stall", 16'({bus_f.wpcir, bus_f.pcsrc}), 16'h0);
    tick();
    drive(enc_i(6'h04, 5'd3, 5'd4, 16'h8), 1'b1, 1'b0);
    chk("br_taken", 16'({bus_f.wpcir, bus_f.pcsrc}), 16'h5);
    tick();
    drive({6'h02, 26'h100}, 1'b0, 1'b0);
    chk("jump_pcsrc", 16'(bus_f.pcsrc), 16'h2);
    tick();
    nops(3);

    // interlock-only: EX dependency stalls exactly 2 cycles
    drive(enc_r(6'h20, 5'd1, 5'd2, 5'd3), 1'b0, 1'b0); tick();
    drive(enc_r(6'h25, 5'd3, 5'd6, 5'd5), 1'b0, 1'b0);
    chk("ilk_stall1", 16'(bus_i.wpcir), 16'h0);
    tick();
    drive(enc_r(6'h25, 5'd3, 5'd6, 5'd5), 1'b0, 1'b0);
    chk("ilk_stall2", 16'(bus_i.wpcir), 16'h0);
    tick();
    drive(enc_r(6'h25, 5'd3, 5'd6, 5'd5), 1'b0, 1'b0);
    chk("ilk_release", 16'({bus_i.wpcir, bus_i.fwda}), 16'h4);
    tick();

    // unsupported opcode
    drive({6'h3f, 26'h0123456}, 1'b0, 1'b0);
    chk("illegal_flag", 16'(bus_f.illegal), 16'h1);
    chk("illegal_wen", 16'({bus_f.wreg, bus_f.wmem}), 16'h0);
    tick();
    nops(3);

    // reset asserted during a load-use stall
    drive(enc_i(6'h23, 5'd1, 5'd3, 16'h4), 1'b0, 1'b0); tick();
    drive(enc_r(6'h20, 5'd3, 5'd3, 5'd4), 1'b0, 1'b1);
    chk("rststall_stall", 16'(bus_f.wpcir), 16'h0);
    tick();
    drive(enc_r(6'h20, 5'd3, 5'd3, 5'd4), 1'b0, 1'b0);
    chk("rststall_stages", 16'({bus_f.ewreg, bus_f.em2reg, bus_f.ewmem, bus_f.ealuimm,
                               bus_f.mwreg, bus_f.mm2reg, bus_f.mwmem,
                               bus_f.wwreg, bus_f.wm2reg}), 16'h0);
    chk("rststall_wpcir", 16'(bus_f.wpcir), 16'h1);
    tick();

    // random instruction stream with occasional reset
    for (int n = 0; n < 400; n++) begin
      drive(rnd_instr(), 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
